qspi_target: RTL and testbench
==============================

QSPI_TARGET -- requirements
Module: qspi_target

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 64, meaning internal byte-array size (power of 2, 16..1024).
REQ-002 SHALL have parameter DUMMY, default 6, meaning the number of idle nibble cycles between the last address nibble and the first read-data nibble (1..15).
REQ-003 SHALL have port clk  input  1  single clock, also the serial bus clock; all sampling and driving on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cs_n  input  1  active-low chip select from the bus initiator.
REQ-006 SHALL have port sd_in  input  4  nibble sampled from the quad data lines.
REQ-007 SHALL have port sd_out  output  4  nibble driven onto the quad data lines.
REQ-008 SHALL have port sd_oe  output  4  per-line output enable, active high, all bits equal.

Function
REQ-009 SHALL be the responder for the quad-SPI initiator; every transfer unit is one nibble per clk, most-significant nibble first.
REQ-010 SHALL have states IDLE, CMD, ADDR, DUMMY, RDATA, WDATA and IGNORE, all registered.
REQ-011 SHALL leave IDLE on the first edge with cs_n=0 and capture that edge's sd_in as command bits 7:4, entering CMD.
REQ-012 SHALL capture command bits 3:0 in CMD on the next edge; 8'hEB SHALL go to ADDR as read, 8'h38 SHALL go to ADDR as write, and any other value SHALL go to IGNORE.
REQ-013 SHALL capture 6 address nibbles (24 bits, MSN first) in ADDR and use only address[log2(MEM_BYTES)-1:0] as the byte index; higher bits SHALL be ignored.
REQ-014 SHALL, for a write, enter WDATA on the edge after the 6th address nibble; for a read, it SHALL enter DUMMY and count DUMMY edges.
REQ-015 SHALL register sd_out = mem[idx][7:4] and sd_oe = 4'hF on the final DUMMY edge, so the first data nibble is valid for the whole following cycle.
REQ-016 SHALL, in RDATA, alternate high and low nibbles on successive edges; after a low nibble, idx SHALL increment.
REQ-017 SHALL, in WDATA, hold the first nibble of each pair as bits 7:4 and write the full byte to mem[idx] on the second nibble's edge, then increment idx.
REQ-018 SHALL wrap idx from MEM_BYTES-1 to 0 with no error indication, for both reads and writes.
REQ-019 SHALL, on any edge with cs_n=1 in any state, go to IDLE and register sd_oe=0 and sd_out=0.
REQ-020 SHALL discard a write byte with only its high nibble received when cs_n rises; memory SHALL be unchanged.
REQ-021 SHALL, in IGNORE, keep sd_oe=0 and ignore sd_in until cs_n=1.
REQ-022 SHALL keep sd_oe=0 in CMD, ADDR, DUMMY and WDATA; there SHALL be no bus contention with the initiator.
REQ-023 SHALL read data written earlier in the same transaction with the new value; mem is synchronous-write and asynchronous-read.
REQ-024 SHALL have a read latency from cs_n falling edge to the first data nibble valid of 2+6+DUMMY edges, i.e. 14 cycles at default.
REQ-025 SHALL let transactions be back-to-back; one cs_n=1 edge is sufficient between them.

Reset
REQ-026 SHALL, on reset=1 at a clk edge, set state to IGNORE, sd_oe=4'h0, sd_out=4'h0, clear idx and all command and address registers.
REQ-027 SHALL not reset memory contents; the contents after power-up are undefined.
REQ-028 SHALL give reset priority over cs_n; after reset with cs_n held low, the block SHALL stay in IGNORE until cs_n=1, so a transaction in progress is abandoned, never resumed.

Verification
REQ-029 SHALL cover this scenario: write cmd 38, addr 000010, data nibbles 1,2,3,4 then cs_n high -> mem[16]=8'h12, mem[17]=8'h34.
REQ-030 SHALL cover this scenario: read cmd EB, addr 000010, DUMMY=6 -> sd_oe=F from cycle 14; sd_out sequence 1,2,3,4 on cycles 14..17.
REQ-031 SHALL cover this scenario: write at addr 00003F with bytes AA,55 -> mem[63]=AA, mem[0]=55; a read from 3F returns A,A,5,5.
REQ-032 SHALL cover this scenario: write 38 to addr 5 with nibbles 7,8,9 then cs_n high -> mem[5]=78 and mem[6] unchanged; sd_oe stays 0 throughout.
REQ-033 SHALL cover this scenario: cmd 9F -> IGNORE, sd_oe=0 until cs_n rises; the next cycle with cs_n low begins a fresh cmd EB and reads normally.
REQ-034 SHALL cover this scenario: reset pulsed mid-read at the 3rd data nibble with cs_n held low -> sd_oe=0 the next cycle and no drive until cs_n goes 1, then 0, and a new EB is issued.

Source files
------------

// File: rtl/qspi_target.sv
// Quad-SPI memory target: one nibble per clk, MSN first.
// Read command 8'hEB and write command 8'h38 with a 24-bit address into a small byte array.
module qspi_target #(
  parameter int unsigned MEM_BYTES = 64,
  parameter int unsigned DUMMY     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic [3:0] sd_in,
  output logic [3:0] sd_out,
  output logic [3:0] sd_oe
);

  localparam int unsigned IDX_W      = $clog2(MEM_BYTES);
  localparam logic [7:0]  CMD_READ   = 8'hEB;
  localparam logic [7:0]  CMD_WRITE  = 8'h38;
  localparam logic [3:0]  LAST_ADDR  = 4'd5;
  localparam logic [3:0]  LAST_DUMMY = 4'(DUMMY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_RDATA,
    S_WDATA,
    S_IGNORE
  } state_t;

  state_t             state;
  logic [3:0]         cmd_hi;
  logic               is_read;
  logic [3:0]         cnt;
  logic [IDX_W-1:0]   idx;
  logic               phase;
  logic [3:0]         wbuf;
  logic [7:0]         mem [MEM_BYTES];

  logic [7:0]         rd_byte_c;
  logic               mem_we_c;

  // Asynchronous read of the current byte; write lands on the low-nibble edge.
  assign rd_byte_c = mem[idx];
  assign mem_we_c  = !reset && !cs_n && (state == S_WDATA) && phase;

  // Memory contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[idx] <= {wbuf, sd_in};
    end
  end

  // Protocol FSM; sd_oe is only raised from the last dummy edge through RDATA.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IGNORE;
      sd_oe   <= 4'h0;
      sd_out  <= 4'h0;
      idx     <= '0;
      cmd_hi  <= 4'h0;
      is_read <= 1'b0;
      cnt     <= 4'd0;
      phase   <= 1'b0;
      wbuf    <= 4'h0;
    end else if (cs_n) begin
      state  <= S_IDLE;
      sd_oe  <= 4'h0;
      sd_out <= 4'h0;
      cnt    <= 4'd0;
      phase  <= 1'b0;
    end else begin
      sd_oe  <= 4'h0;
      sd_out <= 4'h0;
      case (state)
        S_IDLE: begin
          cmd_hi <= sd_in;
          state  <= S_CMD;
        end
        S_CMD: begin
          cnt <= 4'd0;
          if ({cmd_hi, sd_in} == CMD_READ) begin
            is_read <= 1'b1;
            state   <= S_ADDR;
          end else if ({cmd_hi, sd_in} == CMD_WRITE) begin
            is_read <= 1'b0;
            state   <= S_ADDR;
          end else begin
            state <= S_IGNORE;
          end
        end
        S_ADDR: begin
          // Shifting straight into idx drops the unused high address bits.
          idx <= IDX_W'({idx, sd_in});
          if (cnt == LAST_ADDR) begin
            cnt   <= 4'd0;
            phase <= 1'b0;
            state <= is_read ? S_DUMMY : S_WDATA;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_DUMMY: begin
          if (cnt == LAST_DUMMY) begin
            sd_out <= rd_byte_c[7:4];
            sd_oe  <= 4'hF;
            phase  <= 1'b0;
            state  <= S_RDATA;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_RDATA: begin
          sd_oe <= 4'hF;
          phase <= ~phase;
          if (!phase) begin
            sd_out <= rd_byte_c[3:0];
            idx    <= idx + IDX_W'(1);
          end else begin
            sd_out <= rd_byte_c[7:4];
          end
        end
        S_WDATA: begin
          phase <= ~phase;
          if (!phase) begin
            wbuf <= sd_in;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_IGNORE: begin
          state <= S_IGNORE;
        end
        default: begin
          state <= S_IGNORE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_target.sv
// Directed bench for qspi_target: writes, reads, address wrap, partial write,
// unknown command and reset in the middle of a read.
module tb_qspi_target;

  localparam int unsigned MEM_BYTES = 64;
  localparam int unsigned DUMMY     = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs_n = 1'b1;
  logic [3:0] sd_in = 4'h0;
  logic [3:0] sd_out;
  logic [3:0] sd_oe;

  int n_checks = 0;
  int n_errors = 0;

  qspi_target #(
    .MEM_BYTES(MEM_BYTES),
    .DUMMY    (DUMMY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cs_n  (cs_n),
    .sd_in (sd_in),
    .sd_out(sd_out),
    .sd_oe (sd_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one bus cycle, then sample just after the edge.
  task automatic cyc(input logic c, input logic [3:0] d);
    cs_n  = c;
    sd_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
    cyc(1'b0, cmd[7:4]);
    check("hdr_oe_cmd_hi", 8'(sd_oe), 8'h00);
    cyc(1'b0, cmd[3:0]);
    check("hdr_oe_cmd_lo", 8'(sd_oe), 8'h00);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, addr[23-4*i -: 4]);
      check("hdr_oe_addr", 8'(sd_oe), 8'h00);
    end
  endtask

  // data holds nibbles MSN first starting at bit 63.
  task automatic write_txn(input logic [23:0] addr, input logic [63:0] data, input int n);
    send_hdr(8'h38, addr);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, data[63-4*i -: 4]);
      check("wr_oe", 8'(sd_oe), 8'h00);
    end
    cyc(1'b1, 4'h0);
    check("wr_end_oe", 8'(sd_oe), 8'h00);
  endtask

  task automatic read_txn(input logic [23:0] addr, input logic [63:0] data, input int n);
    send_hdr(8'hEB, addr);
    for (int d = 0; d < int'(DUMMY); d++) begin
      cyc(1'b0, 4'hA);
      if (d < int'(DUMMY) - 1) begin
        check("rd_dummy_oe", 8'(sd_oe), 8'h00);
      end else begin
        check("rd_first_oe", 8'(sd_oe), 8'h0F);
        check("rd_first_nib", 8'(sd_out), 8'(data[63:60]));
      end
    end
    for (int i = 1; i < n; i++) begin
      cyc(1'b0, 4'h0);
      check("rd_oe", 8'(sd_oe), 8'h0F);
      check("rd_nib", 8'(sd_out), 8'(data[63-4*i -: 4]));
    end
    cyc(1'b1, 4'h0);
    check("rd_end_oe", 8'(sd_oe), 8'h00);
    check("rd_end_out", 8'(sd_out), 8'h00);
  endtask

  initial begin
    logic [31:0] junk;
    junk = 32'hEB00_0010;

    // Reset state
    cyc(1'b1, 4'h0);
    cyc(1'b1, 4'h0);
    check("reset_oe", 8'(sd_oe), 8'h00);
    check("reset_out", 8'(sd_out), 8'h00);
    reset = 1'b0;
    cyc(1'b1, 4'h0);

    // Write 12,34 at 0x10 and read it back
    write_txn(24'h000010, 64'h1234_0000_0000_0000, 4);
    read_txn(24'h000010, 64'h1234_0000_0000_0000, 4);

    // Upper address bits are ignored
    read_txn(24'hFFFFD0, 64'h1234_0000_0000_0000, 4);

    // Index wraps from 63 to 0
    write_txn(24'h00003F, 64'hAA55_0000_0000_0000, 4);
    read_txn(24'h00003F, 64'hAA55_0000_0000_0000, 4);
    read_txn(24'h000000, 64'h5500_0000_0000_0000, 2);

    // Half-written byte is dropped
    write_txn(24'h000006, 64'hC300_0000_0000_0000, 2);
    write_txn(24'h000005, 64'h7890_0000_0000_0000, 3);
    read_txn(24'h000005, 64'h78C3_0000_0000_0000, 4);

    // Unknown command: no drive until cs_n rises, then a fresh read works
    cyc(1'b0, 4'h9);
    cyc(1'b0, 4'hF);
    check("ign_oe_cmd", 8'(sd_oe), 8'h00);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, junk[31-4*(i%8) -: 4]);
      check("ign_oe", 8'(sd_oe), 8'h00);
    end
    cyc(1'b1, 4'h0);
    read_txn(24'h000010, 64'h1234_0000_0000_0000, 4);

    // Reset at the 3rd data nibble with cs_n held low
    send_hdr(8'hEB, 24'h000010);
    for (int d = 0; d < int'(DUMMY); d++) cyc(1'b0, 4'h0);
    check("rst_rd_nib1", 8'(sd_out), 8'h01);
    cyc(1'b0, 4'h0);
    check("rst_rd_nib2", 8'(sd_out), 8'h02);
    reset = 1'b1;
    cyc(1'b0, 4'h0);
    check("rst_mid_oe", 8'(sd_oe), 8'h00);
    check("rst_mid_out", 8'(sd_out), 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cyc(1'b0, junk[31-4*(i%8) -: 4]);
      check("rst_hold_oe", 8'(sd_oe), 8'h00);
    end
    cyc(1'b1, 4'h0);
    read_txn(24'h00003F, 64'hAA55_0000_0000_0000, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
